id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register that feeds the ALU for the RV32 core.
- Latches register-file operands and the immediate, applies EX/MEM and MEM/WB forwarding at capture, and decodes ALU control into the 4-bit ALU select.
- Presents registered operands, select and writeback tags to the ALU stage under a valid/ready handshake, with stall and flush support.

Parameters:
- n, 32, datapath width of operands, immediate and forwarded values.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  decode stage presents an instruction
- in_ready  output  1  stage can accept this cycle
- rs1_data, rs2_data  input  n  register-file read data
- imm  input  n  sign-extended immediate
- rs1_addr, rs2_addr, rd_addr  input  5  register indices
- alu_op  input  2  00 = load/store, 01 = branch, 10 = arithmetic, 11 = illegal
- funct3  input  3  instruction funct3
- funct7_5  input  1  instruction bit 30
- alu_src  input  1  1 = op_b takes imm (I-type), 0 = op_b takes rs2
- reg_write  input  1  instruction writes rd
- flush  input  1  kill held and incoming instruction
- exm_rd  input  5  EX/MEM destination index
- exm_we  input  1  EX/MEM writes rd
- exm_val  input  n  EX/MEM result
- wb_rd  input  5  MEM/WB destination index
- wb_we  input  1  MEM/WB writes rd
- wb_val  input  n  MEM/WB result
- out_valid  output  1  outputs hold a live instruction
- out_ready  input  1  ALU stage consumes this cycle
- op_a  output  n  ALU operand a
- op_b  output  n  ALU operand b
- store_data  output  n  forwarded rs2 value
- alu_sel  output  4  ALU select
- rd_out  output  5  destination index
- reg_write_out  output  1  writeback enable, forced 0 when out_valid = 0

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous and active-high. On reset all outputs are 0, including out_valid, alu_sel (4'b0000) and reg_write_out. in_ready is 1 after reset.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture occurs on the rising edge when in_valid && in_ready && !flush.
  - out_valid is set on capture. It clears on the edge where out_ready = 1 and no capture occurs.
  - Outputs stay stable while out_valid && !out_ready.
- Latency: one cycle from capture to out_valid.
- Flush: has priority over capture and hold. On the next edge out_valid = 0 and reg_write_out = 0, and any in_valid beat that cycle is dropped. Data registers may keep stale values.
- Forwarding (resolved at capture, per source operand):
  - If the source index != 0, exm_we = 1 and exm_rd matches, use exm_val.
  - Else, if the source index != 0, wb_we = 1 and wb_rd matches, use wb_val.
  - Otherwise use the register-file data.
  - x0 is never forwarded. EX/MEM wins when both sources match.
- Operands:
  - op_a = forwarded rs1.
  - store_data = forwarded rs2.
  - op_b = imm if alu_src = 1, else forwarded rs2.
- ALU control (registered at capture):
  - alu_op 00: 0010 (add).
  - alu_op 01: 0110 (sub).
  - alu_op 10, funct3 000: 0110 if alu_src = 0 and funct7_5 = 1, else 0010. addi never subtracts.
  - alu_op 10, funct3 111: 0000 (and).
  - alu_op 10, funct3 110: 0001 (or).
  - alu_op 10, any other funct3: 1111.
  - alu_op 11: 1111.
  - The ALU returns 0 for 1111.
- Writeback tag: rd_out captured as given. reg_write_out = reg_write && out_valid.
- Reset mid-stall drops the held instruction immediately, asynchronously.
- Back-to-back: with out_ready held at 1, one instruction is accepted every cycle with no bubble.

Test Plan:
- Reset asserted mid-hold -> out_valid, op_a, op_b, alu_sel and reg_write_out read 0 immediately, without waiting for a clock edge.
- R-type sub: rs1_data = 9, rs2_data = 4, alu_op = 10, funct3 = 000, funct7_5 = 1, alu_src = 0 -> next edge: out_valid = 1, op_a = 9, op_b = 4, alu_sel = 0110.
- addi with funct7_5 = 1: imm = 0xFFFFFFFF, alu_src = 1 -> alu_sel = 0010, op_b = 0xFFFFFFFF.
- Forwarding priority: rs1_addr = 5, exm_rd = 5 with exm_val = 0x11 and exm_we = 1, wb_rd = 5 with wb_val = 0x22 and wb_we = 1 -> op_a = 0x11.
- Forwarding x0: rs1_addr = 0, exm_rd = 0, exm_val = 7, rs1_data = 0 -> op_a = 0.
- Stall: out_ready = 0 for 3 cycles while in_valid = 1 -> in_ready = 0 and outputs unchanged. Then out_ready = 1 -> the new instruction appears on the next edge.
- Flush: flush and in_valid both asserted -> out_valid = 0 on the next edge, and the instruction is never presented.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 core: forwards operands at capture,
// decodes ALU control, and hands off to the ALU under a valid/ready handshake.
module id_ex_stage #(
  parameter int n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [n-1:0] rs1_data,
  input  logic [n-1:0] rs2_data,
  input  logic [n-1:0] imm,
  input  logic [4:0]   rs1_addr,
  input  logic [4:0]   rs2_addr,
  input  logic [4:0]   rd_addr,
  input  logic [1:0]   alu_op,
  input  logic [2:0]   funct3,
  input  logic         funct7_5,
  input  logic         alu_src,
  input  logic         reg_write,
  input  logic         flush,
  input  logic [4:0]   exm_rd,
  input  logic         exm_we,
  input  logic [n-1:0] exm_val,
  input  logic [4:0]   wb_rd,
  input  logic         wb_we,
  input  logic [n-1:0] wb_val,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] op_a,
  output logic [n-1:0] op_b,
  output logic [n-1:0] store_data,
  output logic [3:0]   alu_sel,
  output logic [4:0]   rd_out,
  output logic         reg_write_out
);

  logic         r_valid;
  logic [n-1:0] r_op_a, r_op_b, r_store;
  logic [3:0]   r_sel;
  logic [4:0]   r_rd;
  logic         r_rw;

  logic         w_capture;
  logic [n-1:0] w_rs1_fwd, w_rs2_fwd;
  logic [3:0]   w_sel;

  assign in_ready  = !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  // EX/MEM is the younger result, so it wins over MEM/WB; x0 is never forwarded.
  always_comb begin
    w_rs1_fwd = rs1_data;
    if (rs1_addr != 5'd0 && exm_we && exm_rd == rs1_addr)     w_rs1_fwd = exm_val;
    else if (rs1_addr != 5'd0 && wb_we && wb_rd == rs1_addr)  w_rs1_fwd = wb_val;
  end

  always_comb begin
    w_rs2_fwd = rs2_data;
    if (rs2_addr != 5'd0 && exm_we && exm_rd == rs2_addr)     w_rs2_fwd = exm_val;
    else if (rs2_addr != 5'd0 && wb_we && wb_rd == rs2_addr)  w_rs2_fwd = wb_val;
  end

  // funct7_5 only selects sub for register-register ops; addi has imm bits there.
  always_comb begin
    w_sel = 4'b1111;
    case (alu_op)
      2'b00: w_sel = 4'b0010;
      2'b01: w_sel = 4'b0110;
      2'b10: begin
        case (funct3)
          3'b000:  w_sel = (!alu_src && funct7_5) ? 4'b0110 : 4'b0010;
          3'b111:  w_sel = 4'b0000;
          3'b110:  w_sel = 4'b0001;
          default: w_sel = 4'b1111;
        endcase
      end
      default: w_sel = 4'b1111;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_store <= '0;
      r_sel   <= 4'b0000;
      r_rd    <= 5'd0;
      r_rw    <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_op_a  <= w_rs1_fwd;
      r_op_b  <= alu_src ? imm : w_rs2_fwd;
      r_store <= w_rs2_fwd;
      r_sel   <= w_sel;
      r_rd    <= rd_addr;
      r_rw    <= reg_write;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign op_a          = r_op_a;
  assign op_b          = r_op_b;
  assign store_data    = r_store;
  assign alu_sel       = r_sel;
  assign rd_out        = r_rd;
  assign reg_write_out = r_rw && r_valid;

endmodule
